// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for uart_resp_tx; UART_RESP_TX_CHECKSUM_EN selects the 6-byte frame.
package uart_pkg;
  localparam logic [7:0] UART_SYNC_BYTE = 8'hA5;
`ifdef UART_RESP_TX_CHECKSUM_EN
  localparam int FRAME_BYTES = 6;
`else
  localparam int FRAME_BYTES = 5;
`endif
  localparam int IDX_W = $clog2(FRAME_BYTES);
  typedef enum logic [1:0] {F_IDLE, F_LOAD, F_WAIT} frame_state_t;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_t;
  function automatic logic [7:0] resp_checksum(input logic [7:0] cmd, input logic [7:0] status, input logic [15:0] data);
    return cmd ^ status ^ data[15:8] ^ data[7:0];
  endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 LSB-first byte serialiser with baud counter; accepts a new byte on the last stop cycle.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  ser_state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] bit_cnt;
  logic [7:0] sh;
  logic last;
  assign last = cnt == CW'(CLKS_PER_BIT - 1);
  // done leads the final stop cycle by one so the frame's next LOAD lands on that cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      tx <= 1'b1;
      done <= 1'b0;
      cnt <= '0;
      bit_cnt <= '0;
      sh <= '0;
    end else begin
      cnt <= (state == S_IDLE || last) ? '0 : cnt + 1'b1;
      done <= state == S_STOP && cnt == CW'(CLKS_PER_BIT - 3);
      if (start && (state == S_IDLE || (state == S_STOP && last))) begin
        state <= S_START;
        tx <= 1'b0;
        sh <= data;
      end else if (last) begin
        case (state)
          S_START: begin
            state <= S_DATA;
            tx <= sh[0];
            sh <= sh >> 1;
            bit_cnt <= '0;
          end
          S_DATA: begin
            state <= bit_cnt == 3'd7 ? S_STOP : S_DATA;
            tx <= bit_cnt == 3'd7 ? 1'b1 : sh[0];
            sh <= sh >> 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: rtl/uart_resp_tx.sv
// uart_resp_tx: frames a response (sync, cmd, status, data, optional XOR checksum via UART_RESP_TX_CHECKSUM_EN) and sends it 8N1.
module uart_resp_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD_RATE = 500000,
  parameter logic [7:0] SYNC_BYTE = UART_SYNC_BYTE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [7:0]  msg_cmd,
  input  logic [7:0]  msg_status,
  input  logic [15:0] msg_data,
  output logic        uart_tx,
  output logic        busy
);
  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);
  frame_state_t state;
  logic [IDX_W-1:0] idx;
  logic [FRAME_BYTES*8-1:0] frame;
  logic done;
  logic accept;
  assign accept = msg_valid && msg_ready;
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .start (state == F_LOAD),
    .data  (frame[FRAME_BYTES*8-1 -: 8]),
    .tx    (uart_tx),
    .done  (done)
  );
  // frame shifts left one byte per LOAD so the current byte is always the top one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= F_IDLE;
      idx <= '0;
      frame <= '0;
      busy <= 1'b0;
      msg_ready <= 1'b0;
    end else begin
      case (state)
        F_IDLE: begin
          busy <= accept;
          msg_ready <= !accept;
          if (accept) begin
            state <= F_LOAD;
            idx <= '0;
`ifdef UART_RESP_TX_CHECKSUM_EN
            frame <= {SYNC_BYTE, msg_cmd, msg_status, msg_data, resp_checksum(msg_cmd, msg_status, msg_data)};
`else
            frame <= {SYNC_BYTE, msg_cmd, msg_status, msg_data};
`endif
          end
        end
        F_LOAD: state <= F_WAIT;
        F_WAIT: if (done) begin
          state <= idx == LAST_IDX ? F_IDLE : F_LOAD;
          idx <= idx + 1'b1;
          frame <= frame << 8;
        end
        default: state <= F_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_resp_tx.sv
// tb_uart_resp_tx: checks two instances (default 200 clks/bit and 4 clks/bit) against a bit-level line model.
module tb_uart_resp_tx;
`ifdef UART_RESP_TX_CHECKSUM_EN
  localparam int NB = 6;
`else
  localparam int NB = 5;
`endif
  logic clk = 1'b0;
  logic [1:0] rst_n = 2'b00;
  logic [1:0] valid = 2'b00;
  logic [1:0] ready, tx, busy;
  logic [1:0][7:0] cmd = '0;
  logic [1:0][7:0] st = '0;
  logic [1:0][15:0] dat = '0;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_resp_tx u_slow (
    .clk(clk), .rst_n(rst_n[0]), .msg_valid(valid[0]), .msg_ready(ready[0]),
    .msg_cmd(cmd[0]), .msg_status(st[0]), .msg_data(dat[0]), .uart_tx(tx[0]), .busy(busy[0])
  );
  uart_resp_tx #(.BAUD_RATE(25000000)) u_fast (
    .clk(clk), .rst_n(rst_n[1]), .msg_valid(valid[1]), .msg_ready(ready[1]),
    .msg_cmd(cmd[1]), .msg_status(st[1]), .msg_data(dat[1]), .uart_tx(tx[1]), .busy(busy[1])
  );

  function automatic int cpb(input int d);
    return d == 1 ? 4 : 200;
  endfunction

  task automatic test_reset(input int d);
    rst_n[d] = 1'b0;
    valid[d] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if (tx[d] !== 1'b1 || busy[d] !== 1'b0 || ready[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold dut%0d: tx=%b busy=%b ready=%b, want 1 0 0", d, tx[d], busy[d], ready[d]);
      end
    end
    rst_n[d] = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ready[d] !== 1'b1 || busy[d] !== 1'b0 || tx[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release dut%0d: ready=%b busy=%b tx=%b, want 1 0 1", d, ready[d], busy[d], tx[d]);
    end
  endtask

  task automatic do_accept(input int d, input logic [7:0] c, input logic [7:0] s, input logic [15:0] v,
                           input bit keep, output bit ok);
    int waited = 0;
    valid[d] = 1'b1;
    cmd[d] = c;
    st[d] = s;
    dat[d] = v;
    while (ready[d] !== 1'b1 && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    ok = ready[d] === 1'b1;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL accept_wait dut%0d: ready=%b after %0d cycles, want 1", d, ready[d], waited);
      valid[d] = 1'b0;
      return;
    end
    @(negedge clk);
    if (!keep) begin
      valid[d] = 1'b0;
      cmd[d] = 8'($urandom);
      st[d] = 8'($urandom);
      dat[d] = 16'($urandom);
    end
    n_tests++;
    if (busy[d] !== 1'b1 || ready[d] !== 1'b0 || tx[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_state dut%0d: busy=%b ready=%b tx=%b, want 1 0 1", d, busy[d], ready[d], tx[d]);
    end
  endtask

  task automatic check_frame(input int d, input logic [7:0] c, input logic [7:0] s, input logic [15:0] v,
                             input string name);
    logic [7:0] q[$];
    int cp = cpb(d);
    int len, bad = 0, first = -1;
    logic e, lb = 1'b0, lr = 1'b1;
    q = {8'hA5, c, s, v[15:8], v[7:0]};
    if (NB == 6) q.push_back(c ^ s ^ v[15:8] ^ v[7:0]);
    len = q.size() * 10 * cp;
    for (int k = 0; k < len; k++) begin
      int pos;
      logic [7:0] b;
      @(negedge clk);
      b = q[k / (10 * cp)];
      pos = (k % (10 * cp)) / cp;
      e = pos == 0 ? 1'b0 : pos == 9 ? 1'b1 : b[pos-1];
      if (tx[d] !== e) begin
        if (bad == 0) first = k;
        bad++;
      end
      lb = busy[d];
      lr = ready[d];
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s_wave dut%0d: %0d wrong line samples (first at sample %0d), want 0", name, d, bad, first);
    end
    n_tests++;
    if (lb !== 1'b1 || lr !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_tail dut%0d: busy=%b ready=%b in last stop cycle, want 1 0", name, d, lb, lr);
    end
    @(negedge clk);
    n_tests++;
    if (busy[d] !== 1'b0 || ready[d] !== 1'b1 || tx[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_end dut%0d: busy=%b ready=%b tx=%b, want 0 1 1", name, d, busy[d], ready[d], tx[d]);
    end
  endtask

  task automatic test_basic;
    bit ok;
    do_accept(0, 8'h01, 8'h00, 16'h1234, 1'b0, ok);
    if (ok) check_frame(0, 8'h01, 8'h00, 16'h1234, "basic");
  endtask

  task automatic test_random;
    bit ok;
    for (int i = 0; i < 12; i++) begin
      logic [7:0] c = 8'($urandom), s = 8'($urandom);
      logic [15:0] v = i == 0 ? 16'h00FF : 16'($urandom);
      do_accept(1, c, s, v, 1'b0, ok);
      if (ok) check_frame(1, c, s, v, "random");
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int stray = 0;
    logic [7:0] c1 = 8'($urandom), s1 = 8'($urandom), c2 = 8'($urandom), s2 = 8'($urandom);
    do_accept(1, c1, s1, 16'hBEEF, 1'b1, ok);
    if (!ok) return;
    cmd[1] = c2;
    st[1] = s2;
    dat[1] = 16'hCAFE;
    check_frame(1, c1, s1, 16'hBEEF, "b2b_first");
    do_accept(1, c2, s2, 16'hCAFE, 1'b0, ok);
    if (!ok) return;
    check_frame(1, c2, s2, 16'hCAFE, "b2b_second");
    repeat (100) begin
      @(negedge clk);
      if (busy[1] !== 1'b0 || tx[1] !== 1'b1) stray++;
    end
    n_tests++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL b2b_no_dup: %0d busy/low cycles after second frame, want 0", stray);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int stray = 0;
    logic [7:0] c = 8'($urandom), s = 8'($urandom);
    logic [15:0] v = 16'($urandom);
    do_accept(0, c, s, v, 1'b0, ok);
    if (!ok) return;
    repeat (2 * 10 * cpb(0) + 4 * cpb(0) + cpb(0) / 2 + 1) @(negedge clk);
    n_tests++;
    if (tx[0] !== s[3]) begin
      n_fail++;
      $display("FAIL mid_bit3: tx=%b, want %b", tx[0], s[3]);
    end
    rst_n[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    n_tests++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: tx=%b busy=%b, want 1 0", tx[0], busy[0]);
    end
    repeat (3 * cpb(0)) begin
      @(negedge clk);
      if (busy[0] !== 1'b0 || tx[0] !== 1'b1) stray++;
    end
    n_tests++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL mid_no_resume: %0d busy/low cycles after reset, want 0", stray);
    end
    c = 8'($urandom);
    s = 8'($urandom);
    v = 16'($urandom);
    do_accept(0, c, s, v, 1'b0, ok);
    if (ok) check_frame(0, c, s, v, "recover");
  endtask

  initial begin
    test_reset(0);
    test_reset(1);
    test_basic();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
